i2c_target_mem: RTL
===================

Name: i2c_target_mem

Overview:
- Synthesizable I2C target (slave) on the I2C side of the multi-bus controller; consumes the scl/sda bus the controller produces.
- Gives benches and emulation builds a self-checking endpoint in place of the behavioural i2c_if responder.
- Decodes START/STOP, matches a 7-bit address, ACKs, and serves a small register file.
- Register file access: first written byte sets the pointer; further bytes write or read with auto-increment.

Parameters:
- I2C_ADDR_WIDTH, 7, target address width.
- I2C_DATA_WIDTH, 8, byte width.
- TARGET_ADDR, 7'h22, address this target responds to.
- MEM_DEPTH, 16, register-file entries (power of two); pointer width PTR_W = log2(MEM_DEPTH).

Ports:
- clk_i  in  1  system clock; must be at least 8x SCL frequency.
- rst_n_i  in  1  asynchronous, active-low reset.
- scl_i  in  1  bus SCL, raw.
- sda_i  in  1  bus SDA, raw.
- scl_o  out  1  open-drain SCL (1 = release); no clock stretching, tied 1.
- sda_o  out  1  open-drain SDA (1 = release, 0 = pull low).
- busy_o  out  1  high from START until STOP.
- addr_hit_o  out  1  one-cycle pulse on address match.
- wr_valid_o  out  1  one-cycle pulse per stored data byte.
- wr_ptr_o  out  PTR_W  location written, valid with wr_valid_o.
- wr_data_o  out  I2C_DATA_WIDTH  byte written, valid with wr_valid_o.

Behaviour:
- Reset values: sda_o=1, scl_o=1, busy_o=0, addr_hit_o=0, wr_valid_o=0, wr_ptr_o=0, wr_data_o=0. Pointer=0, memory=0, state IDLE.
- Input sampling: scl_i and sda_i go through 2-flop synchronizers. Edges are detected on the synced values (rise/fall = one-cycle flags); latency 3 clk from pin.
- START: sda falls while scl high. Valid in any state, so repeated START is supported. Sets busy_o, clears bit count, goes to ADDR.
- STOP: sda rises while scl high. Valid in any state. Clears busy_o, releases sda_o, goes to IDLE. Pointer is kept.
- Bit handling: data is sampled on SCL rise; sda_o is changed only on SCL fall.
- ADDR: shift 8 bits (7 address + R/W).
  - On match: pulse addr_hit_o, go to ADDR_ACK.
  - On mismatch: go to IGNORE with sda_o held 1 until START/STOP.
- ADDR_ACK:
  - On the SCL fall after bit 8: sda_o=0.
  - On the next SCL fall: write goes to WR_DATA with sda_o=1; read goes to RD_DATA and drives the MSB of mem[ptr].
- WR_DATA: shift 8 bits, then go to WR_ACK and drive ACK the same way.
  - First byte after the address sets pointer = byte[PTR_W-1:0]; no wr_valid_o.
  - Each later byte: mem[ptr]=byte, wr_valid_o pulse with pre-increment pointer, then ptr = ptr+1 modulo MEM_DEPTH.
  - The write commits on the 8th SCL rise.
- RD_DATA: shift mem[ptr] MSB first, one bit per SCL fall; ptr increments after bit 8. Then go to RD_ACK with sda_o=1.
- RD_ACK: sample master ACK on the 9th SCL rise.
  - ACK (0): next SCL fall loads the next byte, back to RD_DATA.
  - NACK (1): go to IGNORE; sda_o stays released.
- Wrap: pointer MEM_DEPTH-1 increments to 0, for both reads and writes.
- START/STOP detected mid-byte abandons the partial byte: no write, no pointer change.
- Async reset mid-transfer: all state returns to reset values immediately; sda_o releases.
- Simultaneous SCL and SDA edge in one clk is treated as a data edge, not START/STOP.

Decomposition:
- Shared package i2c_target_pkg holds:
  - state enum: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE;
  - R/W bit constants I2C_WRITE=0, I2C_READ=1.
- One sub-module: i2c_bus_sync. Provides the 2-flop synchronizers plus scl_rise, scl_fall, start_det, stop_det pulses.
- FSM, shift registers and memory live in the top.

Test Plan:
1. Address 7'h22 write with bytes 0x03, 0xA5, 0x5A, then STOP. Expect:
   - ACK on all 4 bytes;
   - wr_valid_o twice: (ptr 3, 0xA5), then (ptr 4, 0x5A);
   - busy_o low after STOP.
2. Write pointer 0x03, repeated START, read 7'h22 for 2 bytes, ACK then NACK, STOP. Expect read data 0xA5, 0x5A; sda_o released after the NACK.
3. Address 7'h23 write. Expect:
   - no ACK (SDA high on 9th clock), no addr_hit_o;
   - sda_o stays 1 through 3 data bytes;
   - memory unchanged.
4. Write pointer 0x0F, data 0x11, 0x22. Expect wr_ptr_o 15 then 0; reading from pointer 0x0F returns 0x11, 0x22.
5. Assert rst_n_i low during the 4th bit of a data byte. Expect:
   - sda_o=1 and busy_o=0 immediately, without waiting for a clock edge;
   - a following transaction to 7'h22 ACKs normally.
6. STOP injected after 5 bits of a write data byte. Expect no wr_valid_o, pointer unchanged, state IDLE.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
// The state enum is used by the top-level FSM; R/W constants decode the address byte LSB.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for raw SCL/SDA plus registered edge and START/STOP flags.
// All flags are one-cycle pulses, three clocks after the pin change.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;
    logic r_scl_rise, r_scl_fall, r_start, r_stop;
    logic w_scl_steady_high;

    // SCL high on both samples means no SCL edge this cycle, so an SDA edge
    // coinciding with an SCL edge is never mistaken for START/STOP.
    assign w_scl_steady_high = r_scl_sync & r_scl_prev;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_meta <= scl_i;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_i;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
            r_scl_rise <= r_scl_sync & ~r_scl_prev;
            r_scl_fall <= ~r_scl_sync & r_scl_prev;
            r_start    <= w_scl_steady_high & r_sda_prev & ~r_sda_sync;
            r_stop     <= w_scl_steady_high & ~r_sda_prev & r_sda_sync;
        end
    end

    // r_sda_prev is the SDA level aligned with the registered flags.
    assign sda_o      = r_sda_prev;
    assign scl_rise_o = r_scl_rise;
    assign scl_fall_o = r_scl_fall;
    assign start_o    = r_start;
    assign stop_o     = r_stop;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a small register file: first written byte sets the pointer,
// further bytes write or read with auto-increment. No clock stretching.
module i2c_target_mem
    import i2c_target_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
    parameter int                        MEM_DEPTH      = 16,
    localparam int                       PTR_W          = $clog2(MEM_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      busy_o,
    output logic                      addr_hit_o,
    output logic                      wr_valid_o,
    output logic [PTR_W-1:0]          wr_ptr_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o
);

    localparam int                DW       = I2C_DATA_WIDTH;
    localparam int                CNT_W    = $clog2(DW) + 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DW - 1);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (w_sda),
        .scl_rise_o (w_scl_rise),
        .scl_fall_o (w_scl_fall),
        .start_o    (w_start),
        .stop_o     (w_stop)
    );

    state_t             r_state, w_state_next;
    logic [DW-1:0]      r_shift, w_shift_next, w_shift_in, w_rd_byte;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic [PTR_W-1:0]   r_ptr, w_ptr_next;
    logic               r_rw, w_rw_next;
    logic               r_first, w_first_next;
    logic               r_sda, w_sda_next;
    logic               r_busy, w_busy_next;
    logic               r_addr_hit, w_addr_hit_next;
    logic               r_wr_valid, w_wr_valid_next;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_next;
    logic [DW-1:0]      r_wr_data, w_wr_data_next;
    logic               w_mem_we;
    logic [DW-1:0]      r_mem [MEM_DEPTH];

    assign w_shift_in = {r_shift[DW-2:0], w_sda};
    assign w_rd_byte  = r_mem[r_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_ptr      <= '0;
            r_rw       <= I2C_WRITE;
            r_first    <= 1'b0;
            r_sda      <= 1'b1;
            r_busy     <= 1'b0;
            r_addr_hit <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_ptr      <= w_ptr_next;
            r_rw       <= w_rw_next;
            r_first    <= w_first_next;
            r_sda      <= w_sda_next;
            r_busy     <= w_busy_next;
            r_addr_hit <= w_addr_hit_next;
            r_wr_valid <= w_wr_valid_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_wr_data  <= w_wr_data_next;
            if (w_mem_we) r_mem[r_ptr] <= w_shift_in;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_ptr_next      = r_ptr;
        w_rw_next       = r_rw;
        w_first_next    = r_first;
        w_sda_next      = r_sda;
        w_busy_next     = r_busy;
        w_addr_hit_next = 1'b0;
        w_wr_valid_next = 1'b0;
        w_wr_ptr_next   = r_wr_ptr;
        w_wr_data_next  = r_wr_data;
        w_mem_we        = 1'b0;

        if (w_start) begin
            w_state_next   = ADDR;
            w_bit_cnt_next = '0;
            w_busy_next    = 1'b1;
            w_sda_next     = 1'b1;
        end else if (w_stop) begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            w_sda_next   = 1'b1;
        end else begin
            unique case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift_next   = w_shift_in;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        if (w_shift_in[DW-1 -: I2C_ADDR_WIDTH] == TARGET_ADDR) begin
                            w_addr_hit_next = 1'b1;
                            w_rw_next       = w_shift_in[0];
                            w_state_next    = ADDR_ACK;
                        end else begin
                            w_state_next = IGNORE;
                        end
                    end
                end
                // Two falls in the ACK slot: the first pulls SDA low, the
                // second ends the ACK; r_sda tells which one this is.
                ADDR_ACK: if (w_scl_fall) begin
                    if (r_sda) begin
                        w_sda_next = 1'b0;
                    end else begin
                        w_bit_cnt_next = '0;
                        if (r_rw == I2C_READ) begin
                            w_state_next = RD_DATA;
                            w_shift_next = w_rd_byte;
                            w_sda_next   = w_rd_byte[DW-1];
                        end else begin
                            w_state_next = WR_DATA;
                            w_sda_next   = 1'b1;
                            w_first_next = 1'b1;
                        end
                    end
                end
                WR_DATA: if (w_scl_rise) begin
                    w_shift_next   = w_shift_in;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = WR_ACK;
                        if (r_first) begin
                            w_ptr_next   = w_shift_in[PTR_W-1:0];
                            w_first_next = 1'b0;
                        end else begin
                            w_mem_we        = 1'b1;
                            w_wr_valid_next = 1'b1;
                            w_wr_ptr_next   = r_ptr;
                            w_wr_data_next  = w_shift_in;
                            w_ptr_next      = r_ptr + 1'b1;
                        end
                    end
                end
                WR_ACK: if (w_scl_fall) begin
                    if (r_sda) begin
                        w_sda_next = 1'b0;
                    end else begin
                        w_sda_next     = 1'b1;
                        w_state_next   = WR_DATA;
                        w_bit_cnt_next = '0;
                    end
                end
                RD_DATA: if (w_scl_fall) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_sda_next   = 1'b1;
                        w_state_next = RD_ACK;
                        w_ptr_next   = r_ptr + 1'b1;
                    end else begin
                        w_shift_next   = r_shift << 1;
                        w_sda_next     = r_shift[DW-2];
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_next = IGNORE;
                    end else if (w_scl_fall) begin
                        w_state_next   = RD_DATA;
                        w_shift_next   = w_rd_byte;
                        w_sda_next     = w_rd_byte[DW-1];
                        w_bit_cnt_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign scl_o      = 1'b1;
    assign sda_o      = r_sda;
    assign busy_o     = r_busy;
    assign addr_hit_o = r_addr_hit;
    assign wr_valid_o = r_wr_valid;
    assign wr_ptr_o   = r_wr_ptr;
    assign wr_data_o  = r_wr_data;

endmodule
